mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 16: operand, result and iteration-count width.
REQ-002 SHALL have parameter MAX_ITER, default 16'hFFFF: iteration limit before error.
REQ-003 SHALL have port clock, input, 1: the single clock, rising-edge active.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1: request a multiply, sampled in IDLE only.
REQ-006 SHALL have port abort, input, 1: synchronous abort of any operation in progress.
REQ-007 SHALL have port in_valid, input, 1: operand present on the shared datapath input bus.
REQ-008 SHALL have port in_ready, output, 1: controller accepts an operand this cycle.
REQ-009 SHALL have port eqz, input, 1: B counter equals zero, from the datapath.
REQ-010 SHALL have ports LoadA, LoadB, ClearP, LoadP, decB, all output, 1 each: datapath register controls.
REQ-011 SHALL have port busy, output, 1: the FSM is not in IDLE.
REQ-012 SHALL have port done, output, 1: product valid in P and held until ack.
REQ-013 SHALL have port err, output, 1: the iteration limit was exceeded.
REQ-014 SHALL have port ack, input, 1: consumer has taken the result or error.
REQ-015 SHALL have port iter_cnt, output, W: additions performed in the current operation.

Function
REQ-016 SHALL implement states IDLE, GET_A, GET_B, ADD, DONE, ERR.
REQ-017 IDLE: SHALL go to GET_A on start=1; otherwise SHALL stay in IDLE.
REQ-018 GET_A: SHALL drive in_ready=1; on in_valid=1 SHALL pulse LoadA for one cycle and go to GET_B; otherwise SHALL wait.
REQ-019 GET_B: SHALL drive in_ready=1; on in_valid=1 SHALL pulse LoadB and ClearP in the same cycle, clear iter_cnt and go to ADD.
REQ-020 ADD with eqz=0: SHALL drive LoadP=1 and decB=1 in the same cycle and increment iter_cnt.
REQ-021 ADD with eqz=1: SHALL drive LoadP=0 and decB=0 and go to DONE.
REQ-022 LoadP and decB SHALL be Mealy on eqz, so an add is never issued when B=0.
REQ-023 ADD: if iter_cnt equals MAX_ITER while eqz=0, SHALL issue no add and go to ERR.
REQ-024 DONE: SHALL drive done=1 and hold P with no Load/dec outputs; on ack=1 SHALL go to IDLE.
REQ-025 ERR: SHALL drive err=1; on ack=1 SHALL go to IDLE.
REQ-026 Latency, both operands valid with no stall: start accepted in cycle T, LoadA at T+1, LoadB at T+2, adds at T+3..T+2+B, done=1 from T+3+B.
REQ-027 B=0: done SHALL assert at T+3 with P=0 and iter_cnt=0.
REQ-028 abort=1 in any state except IDLE SHALL force IDLE next cycle with every datapath control 0 that cycle; abort SHALL take priority over in_valid, eqz and ack.
REQ-029 start while busy SHALL be ignored; ack outside DONE/ERR SHALL be ignored.
REQ-030 iter_cnt SHALL hold its final value in DONE and ERR and SHALL not wrap.
REQ-031 Datapath control outputs SHALL be 0 in IDLE, DONE and ERR.

Reset
REQ-032 reset_n=0 at a clock edge SHALL force IDLE, iter_cnt=0, and busy, done, err, in_ready and all datapath controls to 0, overriding every other input including mid-operation.

Structure
REQ-033 Package mul_pkg SHALL hold the state enumeration and the default W and MAX_ITER constants.
REQ-034 The iteration counter SHALL be the sub-module mul_iter_cnt, with clear, increment and limit-compare functions.
REQ-035 Next-state logic and output decode SHALL be one combinational process, with the state register separate.

Verification
REQ-036 Test A=7, B=5, in_valid held high: done at T+8, P=35, iter_cnt=5, exactly 5 LoadP pulses.
REQ-037 Test A=9, B=0: done at T+3, P=0, no LoadP or decB pulse.
REQ-038 Test in_valid low for 3 cycles in GET_B: in_ready held, LoadB delayed 3 cycles, result still correct (A=3, B=4 gives 12).
REQ-039 Test MAX_ITER=4, B=10: err=1 after 4 adds with iter_cnt=4; ack returns to IDLE.
REQ-040 Test abort in the 2nd ADD cycle: next cycle IDLE, busy=0, no further LoadP; a following start runs normally.
REQ-041 Test reset_n=0 during ADD, and start pulsed while busy: reset gives all outputs 0 and IDLE; the stray start is ignored.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and default parameters for the sequential shift-free multiplier controller.
package mul_pkg;

  localparam int unsigned DEF_W        = 16;
  localparam int unsigned DEF_MAX_ITER = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GET_A = 3'd1,
    S_GET_B = 3'd2,
    S_ADD   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

endpackage

// File: rtl/mul_iter_cnt.sv
// Counts additions in the current multiply and flags when the iteration limit is reached.
module mul_iter_cnt
  import mul_pkg::*;
#(
  parameter int unsigned W        = DEF_W,
  parameter int unsigned MAX_ITER = DEF_MAX_ITER
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_at_limit
);

  logic [W-1:0] r_cnt;
  logic         w_at_limit;

  assign w_at_limit = (r_cnt == W'(MAX_ITER));

  // Saturates at the limit so the count never wraps.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_limit) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt      = r_cnt;
  assign o_at_limit = w_at_limit;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Controller for a repeated-addition multiplier: loads A and B, adds A into P B times,
// then reports done (or err on iteration overflow) until acknowledged.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned W        = DEF_W,
  parameter int unsigned MAX_ITER = DEF_MAX_ITER
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         eqz,
  output logic         LoadA,
  output logic         LoadB,
  output logic         ClearP,
  output logic         LoadP,
  output logic         decB,
  output logic         busy,
  output logic         done,
  output logic         err,
  input  logic         ack,
  output logic [W-1:0] iter_cnt
);

  state_e r_state;
  state_e w_next;
  logic   w_clr;
  logic   w_inc;
  logic   w_at_limit;

  mul_iter_cnt #(
    .W        (W),
    .MAX_ITER (MAX_ITER)
  ) u_iter_cnt (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_clr      (w_clr),
    .i_inc      (w_inc),
    .o_cnt      (iter_cnt),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and output decode; add controls are Mealy on eqz so no add fires with B=0.
  always_comb begin
    w_next   = r_state;
    w_clr    = 1'b0;
    w_inc    = 1'b0;
    in_ready = 1'b0;
    LoadA    = 1'b0;
    LoadB    = 1'b0;
    ClearP   = 1'b0;
    LoadP    = 1'b0;
    decB     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    if (reset_n) begin
      busy = (r_state != S_IDLE);
      if (abort && (r_state != S_IDLE)) begin
        w_next = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) w_next = S_GET_A;
          end
          S_GET_A: begin
            in_ready = 1'b1;
            if (in_valid) begin
              LoadA  = 1'b1;
              w_next = S_GET_B;
            end
          end
          S_GET_B: begin
            in_ready = 1'b1;
            if (in_valid) begin
              LoadB  = 1'b1;
              ClearP = 1'b1;
              w_clr  = 1'b1;
              w_next = S_ADD;
            end
          end
          S_ADD: begin
            // P is final as soon as B reaches zero, so done is reported in this cycle.
            if (eqz) begin
              done   = 1'b1;
              w_next = S_DONE;
            end else if (w_at_limit) begin
              w_next = S_ERR;
            end else begin
              LoadP = 1'b1;
              decB  = 1'b1;
              w_inc = 1'b1;
            end
          end
          S_DONE: begin
            done = 1'b1;
            if (ack) w_next = S_IDLE;
          end
          S_ERR: begin
            err = 1'b1;
            if (ack) w_next = S_IDLE;
          end
          default: w_next = S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: a behavioural A/B/P datapath surrounds two controllers
// (default limit and MAX_ITER=4); results are checked against A*B and cycle-latency rules.
module tb_mul_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset_n, abort, in_valid, ack;
  logic [15:0] bus;
  logic [1:0]  start;
  wire  [1:0]  in_ready, eqz, load_a, load_b, clear_p, load_p, dec_b, busy, done, err;
  wire  [15:0] iter_cnt [2];

  logic [15:0] dp_a [2];
  logic [15:0] dp_b [2];
  logic [31:0] dp_p [2];
  int          lp_total [2];
  int          db_total [2];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mul_seq_ctrl u_dut (
    .clock(clock), .reset_n(reset_n), .start(start[0]), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready[0]), .eqz(eqz[0]),
    .LoadA(load_a[0]), .LoadB(load_b[0]), .ClearP(clear_p[0]), .LoadP(load_p[0]),
    .decB(dec_b[0]), .busy(busy[0]), .done(done[0]), .err(err[0]), .ack(ack),
    .iter_cnt(iter_cnt[0])
  );

  mul_seq_ctrl #(.W(16), .MAX_ITER(4)) u_lim (
    .clock(clock), .reset_n(reset_n), .start(start[1]), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready[1]), .eqz(eqz[1]),
    .LoadA(load_a[1]), .LoadB(load_b[1]), .ClearP(clear_p[1]), .LoadP(load_p[1]),
    .decB(dec_b[1]), .busy(busy[1]), .done(done[1]), .err(err[1]), .ack(ack),
    .iter_cnt(iter_cnt[1])
  );

  assign eqz = {dp_b[1] == 16'd0, dp_b[0] == 16'd0};

  // Behavioural datapath: A and B registers, B down-counter, P accumulator.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (load_a[i]) dp_a[i] <= bus;
      if (load_b[i]) dp_b[i] <= bus;
      else if (dec_b[i]) dp_b[i] <= dp_b[i] - 16'd1;
      if (clear_p[i]) dp_p[i] <= 32'd0;
      else if (load_p[i]) dp_p[i] <= dp_p[i] + 32'(dp_a[i]);
      if (load_p[i]) lp_total[i] <= lp_total[i] + 1;
      if (dec_b[i]) db_total[i] <= db_total[i] + 1;
    end
  end

  // Drives one multiply on instance i; cycle 0 is the cycle start is presented in IDLE.
  task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input int sa, input int sb, input int stray_k,
                        output int lat, output int lb_cyc, output int rdy_stall, output int adds);
    int phase;
    int base;
    phase = 0; lat = -1; lb_cyc = -1; rdy_stall = 0; base = lp_total[i];
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      start[i] = (k == 0) || (k == stray_k);
      in_valid = 1'b0;
      if (k > 0 && phase == 0) begin
        if (sa > 0) sa--; else begin in_valid = 1'b1; bus = a; end
      end else if (k > 0 && phase == 1) begin
        if (sb > 0) sb--; else begin in_valid = 1'b1; bus = b; end
      end
      #1;
      if (phase == 1 && !in_valid && in_ready[i]) rdy_stall++;
      if (phase == 0 && load_a[i]) phase = 1;
      else if (phase == 1 && load_b[i]) begin phase = 2; lb_cyc = k; end
      else if (phase == 2 && (done[i] || err[i])) begin lat = k; break; end
    end
    start[i] = 1'b0;
    in_valid = 1'b0;
    adds = lp_total[i] - base;
  endtask

  task automatic do_ack();
    @(negedge clock); ack = 1'b1;
    @(negedge clock); ack = 1'b0;
    #1;
  endtask

  // Starts a multiply with no stalls and returns at the negedge of the first ADD cycle.
  task automatic go_to_add(input int i, input logic [15:0] a, input logic [15:0] b);
    @(negedge clock); start[i] = 1'b1; in_valid = 1'b0;
    @(negedge clock); start[i] = 1'b0; in_valid = 1'b1; bus = a;
    @(negedge clock); bus = b;
    @(negedge clock); in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; abort = 1'b0; in_valid = 1'b0; ack = 1'b0; start = 2'b00; bus = 16'd0;
    repeat (3) @(negedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({in_ready[i], load_a[i], load_b[i], clear_p[i], load_p[i], dec_b[i], busy[i], done[i], err[i]} !== 9'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got busy=%b done=%b err=%b rdy=%b expected all 0",
                 i, busy[i], done[i], err[i], in_ready[i]);
      end
    end
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock); #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy[i] !== 1'b0 || iter_cnt[i] !== 16'd0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got busy=%b iter=%0d expected busy=0 iter=0", i, busy[i], iter_cnt[i]);
      end
    end
  endtask

  task automatic test_basic();
    int lat, lb, rs, adds;
    run_op(0, 16'd7, 16'd5, 0, 0, -1, lat, lb, rs, adds);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 8", lat); end
    checks++; if (dp_p[0] !== 32'd35) begin errors++; $display("FAIL basic_product: got %0d expected 35", dp_p[0]); end
    checks++; if (iter_cnt[0] !== 16'd5) begin errors++; $display("FAIL basic_iter: got %0d expected 5", iter_cnt[0]); end
    checks++; if (adds !== 5) begin errors++; $display("FAIL basic_loadp_pulses: got %0d expected 5", adds); end
    @(negedge clock); #1;
    checks++;
    if (done[0] !== 1'b1 || load_p[0] !== 1'b0 || dec_b[0] !== 1'b0 || dp_p[0] !== 32'd35) begin
      errors++;
      $display("FAIL basic_hold: got done=%b loadp=%b decb=%b p=%0d expected 1 0 0 35", done[0], load_p[0], dec_b[0], dp_p[0]);
    end
    do_ack();
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      errors++; $display("FAIL basic_ack_idle: got busy=%b done=%b expected 0 0", busy[0], done[0]);
    end
  endtask

  task automatic test_b_zero();
    int lat, lb, rs, adds, db0;
    db0 = db_total[0];
    run_op(0, 16'd9, 16'd0, 0, 0, -1, lat, lb, rs, adds);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bzero_done_cycle: got %0d expected 3", lat); end
    checks++; if (dp_p[0] !== 32'd0 || iter_cnt[0] !== 16'd0) begin
      errors++; $display("FAIL bzero_result: got p=%0d iter=%0d expected 0 0", dp_p[0], iter_cnt[0]);
    end
    checks++; if (adds !== 0 || db_total[0] - db0 !== 0) begin
      errors++; $display("FAIL bzero_pulses: got loadp=%0d decb=%0d expected 0 0", adds, db_total[0] - db0);
    end
    do_ack();
  endtask

  task automatic test_stall();
    int lat, lb, rs, adds;
    run_op(0, 16'd3, 16'd4, 0, 3, -1, lat, lb, rs, adds);
    checks++; if (lb !== 5) begin errors++; $display("FAIL stall_loadb_cycle: got %0d expected 5", lb); end
    checks++; if (rs !== 3) begin errors++; $display("FAIL stall_ready_held: got %0d cycles expected 3", rs); end
    checks++; if (lat !== 10 || dp_p[0] !== 32'd12) begin
      errors++; $display("FAIL stall_result: got cycle=%0d p=%0d expected 10 12", lat, dp_p[0]);
    end
    do_ack();
  endtask

  task automatic test_limit();
    int lat, lb, rs, adds;
    run_op(1, 16'd2, 16'd10, 0, 0, -1, lat, lb, rs, adds);
    checks++; if (lat !== 8 || err[1] !== 1'b1 || done[1] !== 1'b0) begin
      errors++; $display("FAIL limit_err: got cycle=%0d err=%b done=%b expected 8 1 0", lat, err[1], done[1]);
    end
    checks++; if (iter_cnt[1] !== 16'd4 || adds !== 4 || dp_p[1] !== 32'd8) begin
      errors++; $display("FAIL limit_count: got iter=%0d adds=%0d p=%0d expected 4 4 8", iter_cnt[1], adds, dp_p[1]);
    end
    @(negedge clock); #1;
    checks++; if (err[1] !== 1'b1 || iter_cnt[1] !== 16'd4 || load_p[1] !== 1'b0) begin
      errors++; $display("FAIL limit_hold: got err=%b iter=%0d loadp=%b expected 1 4 0", err[1], iter_cnt[1], load_p[1]);
    end
    do_ack();
    checks++; if (busy[1] !== 1'b0 || err[1] !== 1'b0) begin
      errors++; $display("FAIL limit_ack_idle: got busy=%b err=%b expected 0 0", busy[1], err[1]);
    end
  endtask

  task automatic test_abort();
    int base, lat, lb, rs, adds;
    base = lp_total[0];
    go_to_add(0, 16'd6, 16'd5);
    @(negedge clock); abort = 1'b1; #1;
    checks++;
    if ({load_a[0], load_b[0], clear_p[0], load_p[0], dec_b[0]} !== 5'd0) begin
      errors++; $display("FAIL abort_controls: got loadp=%b decb=%b expected 0 0", load_p[0], dec_b[0]);
    end
    @(negedge clock); abort = 1'b0; #1;
    checks++; if (busy[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%b rdy=%b expected 0 0", busy[0], in_ready[0]);
    end
    repeat (3) @(negedge clock);
    #1;
    checks++; if (lp_total[0] - base !== 1) begin
      errors++; $display("FAIL abort_adds: got %0d expected 1", lp_total[0] - base);
    end
    run_op(0, 16'd4, 16'd3, 0, 0, -1, lat, lb, rs, adds);
    checks++; if (lat !== 6 || dp_p[0] !== 32'd12) begin
      errors++; $display("FAIL abort_rerun: got cycle=%0d p=%0d expected 6 12", lat, dp_p[0]);
    end
    do_ack();
  endtask

  task automatic test_busy_start();
    int lat, lb, rs, adds;
    run_op(0, 16'd5, 16'd6, 0, 0, 4, lat, lb, rs, adds);
    checks++; if (lat !== 9 || dp_p[0] !== 32'd30 || adds !== 6) begin
      errors++; $display("FAIL busy_start: got cycle=%0d p=%0d adds=%0d expected 9 30 6", lat, dp_p[0], adds);
    end
    do_ack();
  endtask

  task automatic test_reset_mid();
    go_to_add(0, 16'd5, 16'd6);
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1; #1;
    checks++;
    if ({in_ready[0], load_a[0], load_b[0], clear_p[0], load_p[0], dec_b[0], busy[0], done[0], err[0]} !== 9'd0
        || iter_cnt[0] !== 16'd0) begin
      errors++; $display("FAIL reset_mid: got busy=%b loadp=%b iter=%0d expected 0 0 0", busy[0], load_p[0], iter_cnt[0]);
    end
    repeat (2) @(negedge clock);
    #1;
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_mid_stay_idle: got busy=%b expected 0", busy[0]); end
  endtask

  task automatic test_random();
    int lat, lb, rs, adds, sa, sb, exp_lat;
    logic [15:0] a, b;
    for (int n = 0; n < 8; n++) begin
      a = 16'($urandom_range(0, 255));
      b = 16'($urandom_range(0, 15));
      sa = int'($urandom_range(0, 2));
      sb = int'($urandom_range(0, 2));
      exp_lat = 3 + int'(b) + sa + sb;
      run_op(0, a, b, sa, sb, -1, lat, lb, rs, adds);
      checks++; if (lat !== exp_lat) begin
        errors++; $display("FAIL rand_done_cycle a=%0d b=%0d: got %0d expected %0d", a, b, lat, exp_lat);
      end
      checks++; if (dp_p[0] !== 32'(a) * 32'(b)) begin
        errors++; $display("FAIL rand_product a=%0d b=%0d: got %0d expected %0d", a, b, dp_p[0], 32'(a) * 32'(b));
      end
      checks++; if (iter_cnt[0] !== b || adds !== int'(b)) begin
        errors++; $display("FAIL rand_iter a=%0d b=%0d: got iter=%0d adds=%0d expected %0d", a, b, iter_cnt[0], adds, b);
      end
      do_ack();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_b_zero();
    test_stall();
    test_limit();
    test_abort();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
